// File: rtl/seg7_status_display.sv
// Elapsed-time (MM:SS) counter with transport FSM and registered active-low
// seven-segment drive for up to eight HEX digits; paused time blinks.
module seg7_status_display #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BLINK_DIV  = 6000000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_pause,
  input  logic                    i_stop,
  input  logic [3:0]              i_speed,
  input  logic                    i_fast,
  output logic [7*NUM_DIGITS-1:0] o_hex,
  output logic                    o_running,
  output logic                    o_sat
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, STOP} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
  logic          sat_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_on_q;

  logic [6:0]              dig [8];
  logic [7*NUM_DIGITS-1:0] hex_nxt;
  logic                    time_blank;
  logic                    at_max;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1011000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = SEG_BLANK;
    endcase
  endfunction

  assign at_max = (min_tens_q == 4'd5) && (min_ones_q == 4'd9) &&
                  (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
  assign time_blank = (state_q == PAUSE) && !blink_on_q;

  // Display image built from the current registered state and the live switches.
  always_comb begin
    dig[0] = time_blank ? SEG_BLANK : seg_dec(sec_ones_q);
    dig[1] = time_blank ? SEG_BLANK : seg_dec(sec_tens_q);
    dig[2] = time_blank ? SEG_BLANK : seg_dec(min_ones_q);
    dig[3] = time_blank ? SEG_BLANK : seg_dec(min_tens_q);
    dig[4] = (i_speed >= 4'd2 && i_speed <= 4'd8) ? seg_dec(i_speed) : seg_dec(4'd1);
    dig[5] = i_fast ? 7'b0001110 : 7'b0010010;
    dig[6] = SEG_BLANK;
    dig[7] = 7'b0111111;
    case (state_q)
      RUN:     dig[7] = 7'b0101111;
      PAUSE:   dig[7] = 7'b0001100;
      STOP:    dig[7] = 7'b0000110;
      default: dig[7] = 7'b0111111;
    endcase
    hex_nxt = '1;
    for (int k = 0; k < NUM_DIGITS; k++) hex_nxt[7*k +: 7] = dig[k];
  end

  // Only the highest-priority pulse acts; a stop in IDLE/STOP still masks start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      sec_ones_q  <= '0;
      sec_tens_q  <= '0;
      min_ones_q  <= '0;
      min_tens_q  <= '0;
      sat_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      o_hex       <= '1;
      o_running   <= 1'b0;
      o_sat       <= 1'b0;
    end else begin
      o_hex     <= hex_nxt;
      o_running <= (state_q == RUN);
      o_sat     <= sat_q;
      if (i_stop) begin
        if (state_q == RUN || state_q == PAUSE) state_q <= STOP;
      end else if (i_start) begin
        state_q    <= RUN;
        presc_q    <= '0;
        sec_ones_q <= '0;
        sec_tens_q <= '0;
        min_ones_q <= '0;
        min_tens_q <= '0;
        sat_q      <= 1'b0;
      end else if (i_pause) begin
        if (state_q == RUN) begin
          state_q     <= PAUSE;
          blink_cnt_q <= '0;
          blink_on_q  <= 1'b1;
        end else if (state_q == PAUSE) begin
          state_q <= RUN;
        end
      end else if (state_q == RUN) begin
        if (presc_q == PRESC_MAX) begin
          presc_q <= '0;
          if (at_max) begin
            sat_q <= 1'b1;
          end else if (sec_ones_q != 4'd9) begin
            sec_ones_q <= sec_ones_q + 4'd1;
          end else begin
            sec_ones_q <= '0;
            if (sec_tens_q != 4'd5) begin
              sec_tens_q <= sec_tens_q + 4'd1;
            end else begin
              sec_tens_q <= '0;
              if (min_ones_q != 4'd9) begin
                min_ones_q <= min_ones_q + 4'd1;
              end else begin
                min_ones_q <= '0;
                min_tens_q <= min_tens_q + 4'd1;
              end
            end
          end
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end else if (state_q == PAUSE) begin
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_q <= '0;
          blink_on_q  <= ~blink_on_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end
    end
  end

endmodule

// File: doc/seg7_status_display.md
# seg7_status_display

Registered multi-digit seven-segment status controller for the audio recorder top level. Runs an elapsed-time counter (MM:SS, BCD) driven by one-cycle key/control pulses, and shows time, playback speed, fast/slow mode and transport state on up to eight active-low HEX digits. Paused time blinks. It replaces the purely combinational HEX drive in the board wrapper and sits between the debounced key pulses / switch inputs and the HEX pins.

## Interface
- CLK_FREQ, 12000000, `i_clk` cycles per elapsed second (≥2)
- BLINK_DIV, 6000000, cycles per blink half-period (≥1)
- NUM_DIGITS, 8, number of HEX digits driven, legal 4..8
- i_clk  in  1  system clock (12 MHz audio clock in the design)
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle pulse: clear time and run
- i_pause  in  1  one-cycle pulse: toggle RUN/PAUSE
- i_stop  in  1  one-cycle pulse: stop, hold time
- i_speed  in  4  speed selector (switches)
- i_fast  in  1  1 = fast mode, 0 = slow mode
- o_hex  out  7*NUM_DIGITS  segments, active-low, digit k in bits [7k+6:7k], per-digit order gfedcba
- o_running  out  1  high while state is RUN
- o_sat  out  1  time saturated at 59:59

## Operation
- States: IDLE, RUN, PAUSE, STOP.
- Input priority when pulses coincide: stop > start > pause. Only the highest-priority pulse acts.
- IDLE: start → RUN; stop and pause ignored.
- RUN: stop → STOP; start → RUN with time, prescaler and o_sat cleared; pause → PAUSE.
- PAUSE: stop → STOP; start → RUN cleared; pause → RUN with prescaler value retained.
- STOP: start → RUN cleared; pause ignored; stop ignored.
- Prescaler: counts 0..CLK_FREQ-1 only in RUN. Frozen in PAUSE. Cleared on start and reset.
- Tick: the RUN cycle in which the prescaler equals CLK_FREQ-1. The prescaler wraps to 0 on that cycle.
- On a tick, time increments in BCD: sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5.
- At 59:59 a tick does not increment. Instead o_sat is set. Time holds and the state stays RUN.
- o_sat clears only on start or reset.
- Digit 0 = sec_ones, digit 1 = sec_tens, digit 2 = min_ones, digit 3 = min_tens.
  - Decimal glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000.
- Digit 4 (if NUM_DIGITS ≥5) shows i_speed: values 2..8 show that numeral; any other value shows "1".
- Digit 5 (if ≥6) shows i_fast: 1 shows "F"=0001110, 0 shows "S"=0010010.
- Digit 6 (if ≥7) is blank (1111111).
- Digit 7 (if 8) shows the state glyph: IDLE "-"=0111111, RUN "r"=0101111, PAUSE "P"=0001100, STOP "E"=0000110.
- Blink: in PAUSE, a phase counter toggles a visible flag every BLINK_DIV cycles.
  - Digits 0-3 show 1111111 while the flag is low.
  - The phase counter clears and the flag is set high on every entry to PAUSE.
  - Outside PAUSE, digits 0-3 are always visible.

## Timing
- Reset values (async assert): state IDLE, time 00:00, prescaler 0, blink flag 1, o_hex all ones, o_running 0, o_sat 0.
- All outputs are registered. o_hex, o_running and o_sat reflect state, time and inputs from the previous cycle, so latency is 1 cycle.
- Pulse at edge N changes state at edge N. The new display appears at edge N+1.
- First tick after start: the start pulse is taken at edge N, the tick occurs at edge N+CLK_FREQ, and 00:01 is displayed from edge N+CLK_FREQ+1.
- i_speed and i_fast reach o_hex one cycle after they change. No synchronisation is done in-block; the switches are quasi-static.
- Reset asserted mid-count: everything returns to reset values immediately. After release the display shows IDLE 00:00 from the first clock edge.
- Pulses longer than one cycle are illegal. Each high cycle is treated as a separate pulse.

## Test plan
- Reset, then 2 clocks with CLK_FREQ=10, NUM_DIGITS=8, i_speed=3, i_fast=1 → digits 0-3 all 1000000; digit 4 0110000; digit 5 0001110; digit 7 0111111; o_running=0.
- Start pulse, then 105 cycles → o_hex shows 00:10, digit 7 0101111, o_running=1. Pause pulse at prescaler=4, wait 30 cycles, then pause pulse → the next tick arrives 6 RUN cycles later.
- Pause with BLINK_DIV=4 → digits 0-3 visible for 4 cycles, then 1111111 for 4 cycles, repeating; digit 7 0001100; digits 4-5 are never blanked.
- Start, then run to 59:59 plus 3 further ticks → time holds 59:59 and o_sat=1. A start pulse then gives 00:00, o_sat=0 after 1 cycle.
- Start, pause and stop pulsed in the same cycle while in RUN → STOP with time held; digit 7 0000110. Stop and start in the same cycle from STOP → stays STOP.
- i_speed sweep 0..15 → digit 4 shows 1,1,2..8,1×7. With NUM_DIGITS=4 the output is 28 bits showing only time; reset asserted at 00:07 → IDLE 00:00.
